lcd_controller: RTL and testbench
=================================

# lcd_controller

Drives the 16x2 HD44780 character LCD from the two 16-character ASCII lines produced by the driver-selection stage: name bytes on line 0, car-model bytes on line 1. It initialises the panel after power-up and then rewrites both lines continuously. Each frame latches a coherent snapshot of both lines. It is the stage directly downstream of driver selection; the top level concatenates M0..M15 and C0..C15 into the two line buses.

## Interface
- POWERUP_CYC, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- EN_CYC, 12: cycles LCD_EN is held high per byte.
- CMD_WAIT, 2500: EN-low wait after every byte except clear (50 us).
- CLEAR_WAIT, 100000: EN-low wait after the 0x01 clear command (2 ms).
- clk  in  1  system clock, 50 MHz; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- line0_data  in  128  line 0 characters; [127:120] = column 0 (M0), [7:0] = column 15.
- line1_data  in  128  line 1 characters, same packing (C0 in [127:120]).
- LCD_DATA  out  8  panel data bus.
- LCD_RS  out  1  0 = command, 1 = character data.
- LCD_RW  out  1  tied 0 (write only).
- LCD_EN  out  1  panel enable strobe.
- LCD_ON  out  1  panel power; 0 in reset, 1 otherwise.
- LCD_BLON  out  1  backlight; 0 in reset, 1 otherwise.
- frame_done  out  1  one-cycle pulse after the last byte of each frame completes.

## Operation
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=0, LCD_BLON=0, frame_done=0. The FSM is in POWERUP with all counters cleared.
- FSM states: POWERUP → INIT → ADDR0 → LINE0 → ADDR1 → LINE1 → ADDR0 (repeats forever).
- POWERUP: counts POWERUP_CYC cycles with EN=0, then goes to INIT.
- INIT: writes four commands in order with RS=0: 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x01 (clear), 0x06 (entry increment).
- ADDR0: writes command 0x80. In the cycle this write starts, both line buses are latched into internal snapshot registers.
- LINE0: 16 writes with RS=1, taken from snapshot line 0 in the order column 0 → 15.
- ADDR1: writes command 0xC0.
- LINE1: 16 writes with RS=1 from snapshot line 1. After the last byte's wait completes, frame_done pulses for one cycle and the FSM enters ADDR0.
- Input changes mid-frame do not affect the frame in progress. They appear in the next frame.
- Byte values are passed through unchecked. Any 8-bit value, including 0x22 and 0x00, is written as given.

## Timing
- Each byte write has three phases:
  - SETUP: 1 cycle. LCD_DATA and LCD_RS are driven, EN=0.
  - PULSE: EN_CYC cycles, EN=1.
  - WAIT: CMD_WAIT cycles (CLEAR_WAIT for the 0x01 command), EN=0.
- LCD_DATA and LCD_RS stay stable from SETUP through the end of WAIT. They change only in the next byte's SETUP cycle.
- Normal byte length: 1+EN_CYC+CMD_WAIT cycles. Clear byte length: 1+EN_CYC+CLEAR_WAIT cycles.
- Steady-state frame: 34 bytes (2 address commands + 32 characters). Period between frame_done pulses = 34·(1+EN_CYC+CMD_WAIT) cycles.
- First EN rising edge after reset release: cycle POWERUP_CYC+1.
- Counter widths are sized with $clog2 of the largest parameter. Counters saturate at no value and never wrap inside a phase.
- Reset asserted at any point, including while EN=1: all outputs go to reset values asynchronously. Operation restarts at POWERUP, including the full power-up wait and INIT, on release.
- frame_done never pulses during POWERUP or INIT.

## Structure
- Shared package lcd_pkg holds:
  - the command constants LCD_FUNC_SET=0x38, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_ENTRY=0x06, LCD_LINE0=0x80, LCD_LINE1=0xC0;
  - the FSM state enum.
- One sub-module, lcd_byte_writer, runs one SETUP/PULSE/WAIT cycle:
  - inputs: start, data, rs, long_wait;
  - outputs: busy and done, plus the pin drivers.
- The top FSM sequences bytes through lcd_byte_writer and holds the snapshot registers and the column index (0–15).

## Test plan
Bench parameters: POWERUP_CYC=10, EN_CYC=4, CMD_WAIT=8, CLEAR_WAIT=20.
- Release reset → LCD_EN=0 for cycles 1–10; first EN rise at cycle 11 with DATA=0x38, RS=0; LCD_ON=LCD_BLON=1 from the first cycle after release.
- Init sequence → EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0; each pulse exactly 4 cycles; gap after 0x01 is 20 EN-low cycles, other gaps 8.
- line0="Joao Rodrigues  ", line1="Fiat-Uno       " padded with 0x20 → bus shows 0x80, then RS=1 bytes 0x4A, 0x6F, 0x61, 0x6F, 0x20, 0x52, …, then 0xC0, then 0x46, 0x69, 0x61, 0x74, 0x2D, …
- Change line0 to "Pedro Henrique  " during LINE0 column 5 → rest of the current frame still shows the Joao bytes; the next frame after 0x80 starts with 0x50, 0x65.
- Steady state → consecutive frame_done pulses exactly 442 cycles apart (34·13); each pulse is 1 cycle wide.
- Assert rst while LCD_EN=1 in LINE1 → EN, RS, DATA, ON, BLON go to 0 with no clock edge; after release the POWERUP delay of 10 cycles and INIT repeat, and no frame_done appears before the next complete frame.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 16x2 character LCD controller:
// panel command bytes, sequencer/writer state encodings and a column selector.
package lcd_pkg;

   localparam logic [7:0] LCD_FUNC_SET = 8'h38;
   localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
   localparam logic [7:0] LCD_CLEAR    = 8'h01;
   localparam logic [7:0] LCD_ENTRY    = 8'h06;
   localparam logic [7:0] LCD_LINE0    = 8'h80;
   localparam logic [7:0] LCD_LINE1    = 8'hC0;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT,
      ST_ADDR0,
      ST_LINE0,
      ST_ADDR1,
      ST_LINE1
   } lcd_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SETUP,
      PH_PULSE,
      PH_WAIT
   } wr_phase_e;

   // Column 0 sits in the top byte, so the bit offset is (15-col)*8 = {~col,3'b000}.
   function automatic logic [7:0] line_char(input logic [127:0] line, input logic [3:0] col);
      return line[{~col, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Runs one SETUP / PULSE / WAIT byte cycle on the LCD pins. A new start is
// accepted while idle or in the final WAIT cycle so bytes can run back to back.
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_CYC     = 12,
   parameter int CMD_WAIT   = 2500,
   parameter int CLEAR_WAIT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       rs,
   input  logic       long_wait,
   output logic       busy,
   output logic       done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en
);

   localparam int MAX_WAIT = (CLEAR_WAIT > CMD_WAIT) ? CLEAR_WAIT : CMD_WAIT;
   localparam int MAX_CYC  = (MAX_WAIT > EN_CYC) ? MAX_WAIT : EN_CYC;
   localparam int CW       = $clog2(MAX_CYC + 1);

   wr_phase_e     phase_reg, phase_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [7:0]    data_reg, data_next;
   logic          rs_reg, rs_next;
   logic          long_reg, long_next;
   logic [CW-1:0] wait_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg <= PH_IDLE;
         cnt_reg   <= '0;
         data_reg  <= 8'h00;
         rs_reg    <= 1'b0;
         long_reg  <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         rs_reg    <= rs_next;
         long_reg  <= long_next;
      end
   end

   always_comb begin
      wait_last  = long_reg ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
      done       = (phase_reg == PH_WAIT) && (cnt_reg == wait_last);
      phase_next = phase_reg;
      cnt_next   = cnt_reg;
      data_next  = data_reg;
      rs_next    = rs_reg;
      long_next  = long_reg;
      case (phase_reg)
         PH_SETUP: begin
            phase_next = PH_PULSE;
            cnt_next   = '0;
         end
         PH_PULSE: begin
            if (cnt_reg == CW'(EN_CYC - 1)) begin
               phase_next = PH_WAIT;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         PH_WAIT: begin
            if (done) phase_next = PH_IDLE;
            else      cnt_next   = cnt_reg + 1'b1;
         end
         default: ;
      endcase
      // Data and RS are only re-latched here, so they hold through the whole WAIT.
      if (start && (phase_reg == PH_IDLE || done)) begin
         phase_next = PH_SETUP;
         cnt_next   = '0;
         data_next  = data;
         rs_next    = rs;
         long_next  = long_wait;
      end
   end

   assign busy     = (phase_reg != PH_IDLE);
   assign lcd_en   = (phase_reg == PH_PULSE);
   assign lcd_data = data_reg;
   assign lcd_rs   = rs_reg;

endmodule

// File: rtl/lcd_controller.sv
// HD44780 16x2 controller: power-up wait, init commands, then continuous
// rewrite of both lines from a snapshot latched at the start of each frame.
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC = 750000,
   parameter int EN_CYC      = 12,
   parameter int CMD_WAIT    = 2500,
   parameter int CLEAR_WAIT  = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] line0_data,
   input  logic [127:0] line1_data,
   output logic [7:0]   LCD_DATA,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic         LCD_EN,
   output logic         LCD_ON,
   output logic         LCD_BLON,
   output logic         frame_done
);

   localparam int PU_W = $clog2(POWERUP_CYC + 1);

   lcd_state_e      state_reg, state_next;
   logic [3:0]      idx_reg, idx_next;
   logic [PU_W-1:0] pu_cnt_reg, pu_cnt_next;
   logic [127:0]    snap0_reg, snap1_reg;
   logic            frame_done_reg, frame_done_next;
   logic            on_reg;
   logic            advance, snap_load;
   logic            wr_start, wr_rs, wr_long, wr_busy, wr_done;
   logic [7:0]      wr_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_POWERUP;
         idx_reg        <= 4'd0;
         pu_cnt_reg     <= '0;
         snap0_reg      <= '0;
         snap1_reg      <= '0;
         frame_done_reg <= 1'b0;
         on_reg         <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         pu_cnt_reg     <= pu_cnt_next;
         frame_done_reg <= frame_done_next;
         on_reg         <= 1'b1;
         if (snap_load) begin
            snap0_reg <= line0_data;
            snap1_reg <= line1_data;
         end
      end
   end

   // (state_reg, idx_reg) names the byte in flight; on advance the next byte
   // is issued in the same cycle its predecessor's WAIT ends.
   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      pu_cnt_next     = pu_cnt_reg;
      frame_done_next = 1'b0;
      advance         = 1'b0;
      snap_load       = 1'b0;
      wr_data         = 8'h00;
      wr_rs           = 1'b0;
      wr_long         = 1'b0;

      if (state_reg == ST_POWERUP) begin
         pu_cnt_next = pu_cnt_reg + 1'b1;
         advance     = (pu_cnt_reg == PU_W'(POWERUP_CYC - 1)) && !wr_busy;
      end else begin
         advance = wr_done;
      end

      if (advance) begin
         idx_next = idx_reg + 4'd1;
         case (state_reg)
            ST_POWERUP: begin
               state_next = ST_INIT;
               idx_next   = 4'd0;
            end
            ST_INIT: begin
               if (idx_reg == 4'd3) begin
                  state_next = ST_ADDR0;
                  idx_next   = 4'd0;
               end
            end
            ST_ADDR0: begin
               state_next = ST_LINE0;
               idx_next   = 4'd0;
            end
            ST_LINE0: begin
               if (idx_reg == 4'd15) begin
                  state_next = ST_ADDR1;
                  idx_next   = 4'd0;
               end
            end
            ST_ADDR1: begin
               state_next = ST_LINE1;
               idx_next   = 4'd0;
            end
            default: begin
               if (idx_reg == 4'd15) begin
                  state_next      = ST_ADDR0;
                  idx_next        = 4'd0;
                  frame_done_next = 1'b1;
               end
            end
         endcase
      end

      case (state_next)
         ST_INIT: begin
            case (idx_next[1:0])
               2'd0:    wr_data = LCD_FUNC_SET;
               2'd1:    wr_data = LCD_DISP_ON;
               2'd2:    wr_data = LCD_CLEAR;
               default: wr_data = LCD_ENTRY;
            endcase
            wr_long = (idx_next == 4'd2);
         end
         ST_ADDR0: begin
            wr_data   = LCD_LINE0;
            snap_load = advance;
         end
         ST_LINE0: begin
            wr_data = line_char(snap0_reg, idx_next);
            wr_rs   = 1'b1;
         end
         ST_ADDR1: wr_data = LCD_LINE1;
         ST_LINE1: begin
            wr_data = line_char(snap1_reg, idx_next);
            wr_rs   = 1'b1;
         end
         default: ;
      endcase
      wr_start = advance;
   end

   lcd_byte_writer #(
      .EN_CYC    (EN_CYC),
      .CMD_WAIT  (CMD_WAIT),
      .CLEAR_WAIT(CLEAR_WAIT)
   ) u_writer (
      .clk      (clk),
      .rst      (rst),
      .start    (wr_start),
      .data     (wr_data),
      .rs       (wr_rs),
      .long_wait(wr_long),
      .busy     (wr_busy),
      .done     (wr_done),
      .lcd_data (LCD_DATA),
      .lcd_rs   (LCD_RS),
      .lcd_en   (LCD_EN)
   );

   assign LCD_RW     = 1'b0;
   assign LCD_ON     = on_reg;
   assign LCD_BLON   = on_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with shortened timing parameters; expected
// byte streams and cycle positions are worked out by hand from the timing rules.
module tb_lcd_controller;

   localparam int POWERUP_CYC = 10;
   localparam int EN_CYC      = 4;
   localparam int CMD_WAIT    = 8;
   localparam int CLEAR_WAIT  = 20;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] line0_data;
   logic [127:0] line1_data;
   logic [7:0]   LCD_DATA;
   logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int base = 0;

   int         rise_cyc[$];
   logic [7:0] rise_data[$];
   logic       rise_rs[$];
   int         fall_cyc[$];
   int         fd_cyc[$];
   logic       en_q = 1'b0;
   logic       fd_q = 1'b0;
   bit         fd_wide = 1'b0;

   string s_joao  = "Joao Rodrigues  ";
   string s_fiat  = "Fiat-Uno        ";
   string s_pedro = "Pedro Henrique  ";

   lcd_controller #(
      .POWERUP_CYC(POWERUP_CYC),
      .EN_CYC     (EN_CYC),
      .CMD_WAIT   (CMD_WAIT),
      .CLEAR_WAIT (CLEAR_WAIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .line0_data(line0_data),
      .line1_data(line1_data),
      .LCD_DATA  (LCD_DATA),
      .LCD_RS    (LCD_RS),
      .LCD_RW    (LCD_RW),
      .LCD_EN    (LCD_EN),
      .LCD_ON    (LCD_ON),
      .LCD_BLON  (LCD_BLON),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Records every EN rise (with the byte on the bus), EN fall and frame_done pulse.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (LCD_EN === 1'b1 && en_q !== 1'b1) begin
         rise_cyc.push_back(cyc);
         rise_data.push_back(LCD_DATA);
         rise_rs.push_back(LCD_RS);
      end
      if (LCD_EN !== 1'b1 && en_q === 1'b1) fall_cyc.push_back(cyc);
      if (frame_done === 1'b1) begin
         fd_cyc.push_back(cyc);
         if (fd_q === 1'b1) fd_wide = 1'b1;
      end
      en_q = LCD_EN;
      fd_q = frame_done;
   end

   task automatic wait_rises(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (rise_cyc.size() >= n) ok = 1'b1;
         else begin
            @(posedge clk);
            #2;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_rises: saw %0d EN pulses, required %0d", rise_cyc.size(), n);
      end
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (fd_cyc.size() >= n) ok = 1'b1;
         else begin
            @(posedge clk);
            #2;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_frames: saw %0d frame_done pulses, required %0d", fd_cyc.size(), n);
      end
   endtask

   task automatic test_reset();
      line0_data = "Joao Rodrigues  ";
      line1_data = "Fiat-Uno        ";
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if ({LCD_DATA, LCD_RS, LCD_RW, LCD_EN} !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_bus: got data=%h rs=%b rw=%b en=%b, required all 0", LCD_DATA, LCD_RS, LCD_RW, LCD_EN);
      end
      vectors++;
      if ({LCD_ON, LCD_BLON, frame_done} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_power: got on=%b blon=%b fd=%b, required 000", LCD_ON, LCD_BLON, frame_done);
      end
   endtask

   task automatic test_powerup();
      bit ok;
      @(negedge clk);
      rst  = 1'b0;
      base = cyc;
      for (int c = 1; c <= POWERUP_CYC; c++) begin
         @(posedge clk);
         #2;
         vectors++;
         if (LCD_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL powerup_en_low: cycle %0d en=%b, required 0", c, LCD_EN);
         end
         if (c == 1) begin
            vectors++;
            if ({LCD_ON, LCD_BLON} !== 2'b11) begin
               miscompares++;
               $display("FAIL power_on: got on=%b blon=%b, required 11", LCD_ON, LCD_BLON);
            end
         end
      end
      wait_rises(1, 20, ok);
      if (ok) begin
         vectors++;
         if (rise_cyc[0] - base != 11 || rise_data[0] !== 8'h38 || rise_rs[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL first_en: cycle %0d data %h rs %b, required cycle 11 data 38 rs 0",
                     rise_cyc[0] - base, rise_data[0], rise_rs[0]);
         end
      end
   endtask

   task automatic test_init();
      bit ok;
      logic [7:0] exp_cmd[4];
      int exp_wait[4];
      exp_cmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
      exp_wait = '{8, 8, 20, 8};
      wait_rises(5, 200, ok);
      if (ok) begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rise_data[i] !== exp_cmd[i] || rise_rs[i] !== 1'b0) begin
               miscompares++;
               $display("FAIL init_cmd%0d: got %h rs %b, required %h rs 0", i, rise_data[i], rise_rs[i], exp_cmd[i]);
            end
            vectors++;
            if (fall_cyc[i] - rise_cyc[i] != EN_CYC) begin
               miscompares++;
               $display("FAIL init_pulse%0d: width %0d, required %0d", i, fall_cyc[i] - rise_cyc[i], EN_CYC);
            end
            // EN-low run minus the next byte's one-cycle SETUP is the WAIT length.
            vectors++;
            if (rise_cyc[i+1] - fall_cyc[i] - 1 != exp_wait[i]) begin
               miscompares++;
               $display("FAIL init_wait%0d: got %0d, required %0d", i, rise_cyc[i+1] - fall_cyc[i] - 1, exp_wait[i]);
            end
         end
      end
   endtask

   task automatic test_line_bytes();
      bit ok;
      // Index 10 is line 0 column 5 of frame 1; change line0 while it is being written.
      wait_rises(11, 400, ok);
      line0_data = "Pedro Henrique  ";
      wait_rises(38, 800, ok);
      if (ok) begin
         for (int i = 4; i < 38; i++) begin
            logic [7:0] exp_d;
            logic       exp_rs;
            if (i == 4) begin
               exp_d = 8'h80; exp_rs = 1'b0;
            end else if (i < 21) begin
               exp_d = s_joao[i-5]; exp_rs = 1'b1;
            end else if (i == 21) begin
               exp_d = 8'hC0; exp_rs = 1'b0;
            end else begin
               exp_d = s_fiat[i-22]; exp_rs = 1'b1;
            end
            vectors++;
            if (rise_data[i] !== exp_d || rise_rs[i] !== exp_rs) begin
               miscompares++;
               $display("FAIL frame1_byte%0d: got %h rs %b, required %h rs %b", i, rise_data[i], rise_rs[i], exp_d, exp_rs);
            end
         end
      end
   endtask

   task automatic test_snapshot();
      bit ok;
      logic [7:0] exp_d[3];
      exp_d = '{8'h80, 8'h50, 8'h65};
      wait_rises(41, 200, ok);
      if (ok) begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rise_data[38+i] !== exp_d[i] || rise_data[38+i] !== (i == 0 ? 8'h80 : s_pedro[i-1])) begin
               miscompares++;
               $display("FAIL frame2_byte%0d: got %h, required %h", i, rise_data[38+i], exp_d[i]);
            end
         end
      end
   endtask

   task automatic test_frame_period();
      bit ok;
      wait_frames(2, 1000, ok);
      if (ok) begin
         // Init: SETUP at 10, bytes 13+13+25+13 -> ADDR0 at 74; 442-cycle frame; pulse one cycle later.
         vectors++;
         if (fd_cyc[0] - base != 516) begin
            miscompares++;
            $display("FAIL first_frame_done: cycle %0d, required 516", fd_cyc[0] - base);
         end
         vectors++;
         if (fd_cyc[1] - fd_cyc[0] != 442) begin
            miscompares++;
            $display("FAIL frame_period: got %0d, required 442", fd_cyc[1] - fd_cyc[0]);
         end
         vectors++;
         if (fd_wide !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_done_width: pulse wider than 1 cycle");
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      int r0, d0;
      // Frame 3 starts at index 72; index 92 is line 1 column 2.
      wait_rises(93, 600, ok);
      if (ok) begin
         vectors++;
         if (LCD_EN !== 1'b1 || rise_rs[92] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_state: en=%b rs=%b, required 1 1", LCD_EN, rise_rs[92]);
         end
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({LCD_EN, LCD_RS, LCD_DATA, LCD_ON, LCD_BLON} !== 12'h000) begin
         miscompares++;
         $display("FAIL async_reset: en=%b rs=%b data=%h on=%b blon=%b, required all 0",
                  LCD_EN, LCD_RS, LCD_DATA, LCD_ON, LCD_BLON);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      base = cyc;
      r0   = rise_cyc.size();
      d0   = fd_cyc.size();
      wait_rises(r0 + 5, 200, ok);
      if (ok) begin
         vectors++;
         if (rise_cyc[r0] - base != 11 || rise_data[r0] !== 8'h38) begin
            miscompares++;
            $display("FAIL restart_first_en: cycle %0d data %h, required cycle 11 data 38", rise_cyc[r0] - base, rise_data[r0]);
         end
         vectors++;
         if ({rise_data[r0+1], rise_data[r0+2], rise_data[r0+3], rise_data[r0+4]} !== 32'h0C010680) begin
            miscompares++;
            $display("FAIL restart_init: got %h %h %h %h, required 0c 01 06 80",
                     rise_data[r0+1], rise_data[r0+2], rise_data[r0+3], rise_data[r0+4]);
         end
      end
      wait_frames(d0 + 1, 700, ok);
      if (ok) begin
         vectors++;
         if (fd_cyc[d0] - base != 516) begin
            miscompares++;
            $display("FAIL restart_frame_done: cycle %0d, required 516", fd_cyc[d0] - base);
         end
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_init();
      test_line_bytes();
      test_snapshot();
      test_frame_period();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
